fetch_stage: RTL and testbench
==============================

# fetch_stage

Instruction-fetch stage of the RISC-V pipeline, upstream of the decode stage. It owns the program counter and fetches instructions from the icache. It presents one instruction word per cycle to decode, and the matching PC one cycle later to align with decode's internal instruction register. It absorbs icache misses, decode bubbles and branch redirects from execute by inserting the all-zero bubble word.

## Interface
- RESET_PC, 32'h0000_0000, PC loaded on reset
- FLUSH_CYCLES, 1, dead cycles after a redirect (range 1..15)
- clk  in  1  clock
- rst_h  in  1  reset, asynchronous, active-high
- icache_req  out  1  fetch request
- icache_addr  out  32  fetch address; always equal to the PC register
- icache_hit  in  1  icache_rdata is valid this cycle for icache_addr
- icache_rdata  in  32  instruction word
- stall_from_decoder  in  1  decode bubble: the word presented this cycle is discarded
- branch_taken_from_execute  in  1  redirect request
- branch_target_from_execute  in  32  redirect target
- instr_to_decoder  out  32  instruction word (combinational); 32'h0 = bubble
- pc_from_fetch  out  32  registered PC of the word presented in the previous cycle
- fetch_misaligned  out  1  one-cycle registered pulse: the redirect target had bits [1:0] != 0
- fetch_count  out  32  count of accepted instructions

## Operation
- FSM states: RUN, MISS, FLUSH. Reset state is RUN.
- Reset values:
  - pc = RESET_PC; pc_from_fetch = RESET_PC
  - flush counter = 0; fetch_misaligned = 0; fetch_count = 0
- icache_req = 1 in RUN and MISS, 0 in FLUSH.
- instr_to_decoder = icache_rdata when (state != FLUSH && icache_hit && !branch_taken_from_execute); otherwise 32'h0.
- "Accept" = instr_to_decoder is non-bubble && !stall_from_decoder.
- Per-cycle priority: branch_taken > FLUSH countdown > miss > stall > accept.
  - branch_taken (any state):
    - pc <= {target[31:2], 2'b00}
    - fetch_misaligned <= |target[1:0]
    - flush counter <= FLUSH_CYCLES-1; state -> FLUSH
    - no accept this cycle
  - FLUSH: counter decrements each cycle; when it reads 0, state -> RUN; pc is held.
  - RUN with !icache_hit: state -> MISS, pc held.
  - MISS: stays in MISS until icache_hit. The hit cycle behaves like RUN: accept or stall, then state -> RUN.
  - Stall with hit: pc held and the same word is re-fetched next cycle; state stays RUN.
  - Accept: pc <= pc + 4 (32-bit, wraps 32'hFFFF_FFFC -> 0); fetch_count += 1 (wraps).
- pc_from_fetch <= pc every cycle, regardless of state. This holds the PC of whatever word decode latched.
- fetch_misaligned is cleared to 0 in every cycle without a redirect.

## Timing
- Hit path: with pc = P and a hit in cycle t, instr_to_decoder = M[P] in cycle t; pc = P+4 and pc_from_fetch = P in cycle t+1.
- Steady state: one instruction per cycle with no stalls and all hits.
- Miss: each miss cycle presents 32'h0. The first hit cycle presents the word with no extra delay.
- Redirect in cycle t: bubbles in t .. t+FLUSH_CYCLES. The first fetch of the target is in cycle t+FLUSH_CYCLES+1.
- Redirect during FLUSH restarts the countdown with the new target. Redirect during MISS abandons the miss.
- Stall and redirect in the same cycle: the redirect wins. A stall during FLUSH or a miss has no effect.
- Reset asserted mid-operation: all state returns to reset values immediately (asynchronous). The first fetch is at RESET_PC in the first cycle after deassertion.

## Test plan
- Reset, RESET_PC=0x100, always hit, M[0x100..0x10C] = A,B,C,D:
  - instr_to_decoder is A,B,C,D on consecutive cycles
  - pc_from_fetch is 0x100,0x104,0x108 one cycle behind
  - fetch_count = 4
- Miss at 0x104 for 3 cycles:
  - three 32'h0 words, icache_addr held at 0x104, then B
  - pc_from_fetch tracks 0x104 during the miss; fetch_count is unaffected by the bubbles
- stall_from_decoder high 2 cycles while presenting B:
  - B is presented 3 times; pc advances to 0x108 only after the stall drops
  - fetch_count increments once
- Redirect to 0x200 with FLUSH_CYCLES=2 while presenting C:
  - 3 bubble cycles, icache_req=0 for 2 cycles, then M[0x200]
  - C is not counted
- Redirect to 0x203:
  - fetch_misaligned pulses for exactly 1 cycle; fetch resumes at 0x200
  - a second redirect to 0x300 during FLUSH resumes at 0x300
- PC 0xFFFF_FFFC accepted: next pc = 0x0000_0000. Assert rst_h mid-miss: outputs return to reset values within the same cycle.

Source files
------------

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, fetches from the icache and feeds decode
// one word per cycle, inserting all-zero bubbles on misses, stalls and redirects.
module fetch_stage #(
    parameter logic [31:0] RESET_PC     = 32'h0000_0000,
    parameter int          FLUSH_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst_h,
    output logic        icache_req,
    output logic [31:0] icache_addr,
    input  logic        icache_hit,
    input  logic [31:0] icache_rdata,
    input  logic        stall_from_decoder,
    input  logic        branch_taken_from_execute,
    input  logic [31:0] branch_target_from_execute,
    output logic [31:0] instr_to_decoder,
    output logic [31:0] pc_from_fetch,
    output logic        fetch_misaligned,
    output logic [31:0] fetch_count
);

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        MISS  = 2'd1,
        FLUSH = 2'd2
    } state_t;

    localparam logic [3:0] FLUSH_INIT = 4'(FLUSH_CYCLES - 1);

    state_t      state;
    logic [31:0] pc;
    logic [3:0]  flush_cnt;
    logic        accept;

    assign icache_addr = pc;
    assign icache_req  = (state != FLUSH);

    // The word is visible to decode only when it is real and not being squashed.
    always_comb begin
        instr_to_decoder = 32'h0000_0000;
        if ((state != FLUSH) && icache_hit && !branch_taken_from_execute) begin
            instr_to_decoder = icache_rdata;
        end else begin
            instr_to_decoder = 32'h0000_0000;
        end
    end

    assign accept = (instr_to_decoder != 32'h0000_0000) && !stall_from_decoder;

    // PC, FSM, flush countdown and status registers.
    always_ff @(posedge clk or posedge rst_h) begin
        if (rst_h) begin
            state            <= RUN;
            pc               <= RESET_PC;
            pc_from_fetch    <= RESET_PC;
            flush_cnt        <= 4'd0;
            fetch_misaligned <= 1'b0;
            fetch_count      <= 32'd0;
        end else begin
            pc_from_fetch    <= pc;
            fetch_misaligned <= 1'b0;
            if (branch_taken_from_execute) begin
                pc               <= {branch_target_from_execute[31:2], 2'b00};
                fetch_misaligned <= |branch_target_from_execute[1:0];
                flush_cnt        <= FLUSH_INIT;
                state            <= FLUSH;
            end else begin
                case (state)
                    FLUSH: begin
                        if (flush_cnt == 4'd0) begin
                            state <= RUN;
                        end else begin
                            flush_cnt <= flush_cnt - 4'd1;
                        end
                    end
                    RUN, MISS: begin
                        if (!icache_hit) begin
                            state <= MISS;
                        end else begin
                            state <= RUN;
                            // A stall leaves pc alone so the same word is re-fetched.
                            if (accept) begin
                                pc          <= pc + 32'd4;
                                fetch_count <= fetch_count + 32'd1;
                            end else begin
                                pc          <= pc;
                            end
                        end
                    end
                    default: begin
                        state <= RUN;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed self-checking bench for fetch_stage; the icache model returns
// 32'h1300_0000 + address for every fetch address.
module tb_fetch_stage;

    logic        clk;
    logic        rst_h;
    logic        icache_req;
    logic [31:0] icache_addr;
    logic        icache_hit;
    logic [31:0] icache_rdata;
    logic        stall_from_decoder;
    logic        branch_taken_from_execute;
    logic [31:0] branch_target_from_execute;
    logic [31:0] instr_to_decoder;
    logic [31:0] pc_from_fetch;
    logic        fetch_misaligned;
    logic [31:0] fetch_count;

    int checks = 0;
    int errors = 0;

    fetch_stage #(
        .RESET_PC    (32'h0000_0100),
        .FLUSH_CYCLES(2)
    ) dut (
        .clk                       (clk),
        .rst_h                     (rst_h),
        .icache_req                (icache_req),
        .icache_addr               (icache_addr),
        .icache_hit                (icache_hit),
        .icache_rdata              (icache_rdata),
        .stall_from_decoder        (stall_from_decoder),
        .branch_taken_from_execute (branch_taken_from_execute),
        .branch_target_from_execute(branch_target_from_execute),
        .instr_to_decoder          (instr_to_decoder),
        .pc_from_fetch             (pc_from_fetch),
        .fetch_misaligned          (fetch_misaligned),
        .fetch_count               (fetch_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign icache_rdata = 32'h1300_0000 + icache_addr;

    task automatic do_reset();
        @(negedge clk);
        rst_h = 1'b1;
        icache_hit = 1'b1;
        stall_from_decoder = 1'b0;
        branch_taken_from_execute = 1'b0;
        branch_target_from_execute = 32'h0;
        @(negedge clk);
        rst_h = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst_h = 1'b1;
        icache_hit = 1'b1;
        stall_from_decoder = 1'b0;
        branch_taken_from_execute = 1'b0;
        branch_target_from_execute = 32'h0;
        #1;
        checks++;
        if (icache_addr !== 32'h0000_0100) begin errors++; $display("FAIL reset_addr got %h want %h", icache_addr, 32'h100); end
        checks++;
        if (pc_from_fetch !== 32'h0000_0100) begin errors++; $display("FAIL reset_pcff got %h want %h", pc_from_fetch, 32'h100); end
        checks++;
        if (fetch_count !== 32'd0 || fetch_misaligned !== 1'b0 || icache_req !== 1'b1) begin
            errors++; $display("FAIL reset_misc got cnt=%0d mis=%b req=%b want 0 0 1", fetch_count, fetch_misaligned, icache_req);
        end
        @(negedge clk);
        rst_h = 1'b0;
    endtask

    task automatic test_sequential();
        logic [31:0] exp_w [4];
        logic [31:0] exp_p [4];
        exp_w[0] = 32'h1300_0100; exp_w[1] = 32'h1300_0104;
        exp_w[2] = 32'h1300_0108; exp_w[3] = 32'h1300_010C;
        exp_p[0] = 32'h0;         exp_p[1] = 32'h0000_0100;
        exp_p[2] = 32'h0000_0104; exp_p[3] = 32'h0000_0108;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            #1;
            checks++;
            if (instr_to_decoder !== exp_w[i]) begin errors++; $display("FAIL seq_instr[%0d] got %h want %h", i, instr_to_decoder, exp_w[i]); end
            if (i > 0) begin
                checks++;
                if (pc_from_fetch !== exp_p[i]) begin errors++; $display("FAIL seq_pcff[%0d] got %h want %h", i, pc_from_fetch, exp_p[i]); end
            end
            @(negedge clk);
        end
        checks++;
        if (fetch_count !== 32'd4) begin errors++; $display("FAIL seq_count got %0d want 4", fetch_count); end
    endtask

    task automatic test_miss();
        do_reset();
        #1;
        @(negedge clk);
        icache_hit = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if (instr_to_decoder !== 32'h0 || icache_addr !== 32'h0000_0104) begin
                errors++; $display("FAIL miss_bubble[%0d] got instr=%h addr=%h want 0 104", i, instr_to_decoder, icache_addr);
            end
            if (i > 0) begin
                checks++;
                if (pc_from_fetch !== 32'h0000_0104) begin errors++; $display("FAIL miss_pcff[%0d] got %h want 104", i, pc_from_fetch); end
            end
            @(negedge clk);
        end
        checks++;
        if (fetch_count !== 32'd1) begin errors++; $display("FAIL miss_count_during got %0d want 1", fetch_count); end
        icache_hit = 1'b1;
        #1;
        checks++;
        if (instr_to_decoder !== 32'h1300_0104) begin errors++; $display("FAIL miss_resume got %h want 13000104", instr_to_decoder); end
        @(negedge clk);
        checks++;
        if (fetch_count !== 32'd2 || icache_addr !== 32'h0000_0108) begin
            errors++; $display("FAIL miss_after got cnt=%0d addr=%h want 2 108", fetch_count, icache_addr);
        end
    endtask

    task automatic test_stall();
        do_reset();
        @(negedge clk);
        stall_from_decoder = 1'b1;
        for (int i = 0; i < 3; i++) begin
            if (i == 2) stall_from_decoder = 1'b0;
            #1;
            checks++;
            if (instr_to_decoder !== 32'h1300_0104 || icache_addr !== 32'h0000_0104) begin
                errors++; $display("FAIL stall_hold[%0d] got instr=%h addr=%h want 13000104 104", i, instr_to_decoder, icache_addr);
            end
            @(negedge clk);
        end
        checks++;
        if (icache_addr !== 32'h0000_0108 || fetch_count !== 32'd2) begin
            errors++; $display("FAIL stall_after got addr=%h cnt=%0d want 108 2", icache_addr, fetch_count);
        end
    endtask

    task automatic test_redirect();
        do_reset();
        @(negedge clk);
        @(negedge clk);
        branch_taken_from_execute = 1'b1;
        branch_target_from_execute = 32'h0000_0200;
        stall_from_decoder = 1'b1;
        #1;
        checks++;
        if (instr_to_decoder !== 32'h0) begin errors++; $display("FAIL redir_t0 got %h want 0", instr_to_decoder); end
        @(negedge clk);
        branch_taken_from_execute = 1'b0;
        stall_from_decoder = 1'b0;
        for (int i = 0; i < 2; i++) begin
            #1;
            checks++;
            if (instr_to_decoder !== 32'h0 || icache_req !== 1'b0 || icache_addr !== 32'h0000_0200) begin
                errors++; $display("FAIL redir_flush[%0d] got instr=%h req=%b addr=%h want 0 0 200", i, instr_to_decoder, icache_req, icache_addr);
            end
            @(negedge clk);
        end
        #1;
        checks++;
        if (instr_to_decoder !== 32'h1300_0200 || icache_req !== 1'b1) begin
            errors++; $display("FAIL redir_target got instr=%h req=%b want 13000200 1", instr_to_decoder, icache_req);
        end
        @(negedge clk);
        checks++;
        if (fetch_count !== 32'd3) begin errors++; $display("FAIL redir_count got %0d want 3", fetch_count); end
    endtask

    task automatic test_misaligned();
        do_reset();
        branch_taken_from_execute = 1'b1;
        branch_target_from_execute = 32'h0000_0203;
        @(negedge clk);
        checks++;
        if (fetch_misaligned !== 1'b1 || icache_addr !== 32'h0000_0200) begin
            errors++; $display("FAIL mis_pulse got mis=%b addr=%h want 1 200", fetch_misaligned, icache_addr);
        end
        branch_target_from_execute = 32'h0000_0300;
        @(negedge clk);
        branch_taken_from_execute = 1'b0;
        checks++;
        if (fetch_misaligned !== 1'b0 || icache_addr !== 32'h0000_0300) begin
            errors++; $display("FAIL mis_clear got mis=%b addr=%h want 0 300", fetch_misaligned, icache_addr);
        end
        @(negedge clk);
        #1;
        checks++;
        if (icache_req !== 1'b0) begin errors++; $display("FAIL mis_refl got req=%b want 0", icache_req); end
        @(negedge clk);
        #1;
        checks++;
        if (instr_to_decoder !== 32'h1300_0300) begin errors++; $display("FAIL mis_resume got %h want 13000300", instr_to_decoder); end
    endtask

    task automatic test_wrap_and_async_reset();
        do_reset();
        branch_taken_from_execute = 1'b1;
        branch_target_from_execute = 32'hFFFF_FFFC;
        @(negedge clk);
        branch_taken_from_execute = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #1;
        checks++;
        if (instr_to_decoder !== 32'h12FF_FFFC) begin errors++; $display("FAIL wrap_instr got %h want 12fffffc", instr_to_decoder); end
        @(negedge clk);
        checks++;
        if (icache_addr !== 32'h0 || pc_from_fetch !== 32'hFFFF_FFFC) begin
            errors++; $display("FAIL wrap_pc got addr=%h pcff=%h want 0 fffffffc", icache_addr, pc_from_fetch);
        end
        icache_hit = 1'b0;
        @(negedge clk);
        @(posedge clk);
        #2;
        rst_h = 1'b1;
        #1;
        checks++;
        if (icache_addr !== 32'h0000_0100 || pc_from_fetch !== 32'h0000_0100 || fetch_count !== 32'd0 || icache_req !== 1'b1) begin
            errors++; $display("FAIL async_reset got addr=%h pcff=%h cnt=%0d req=%b want 100 100 0 1", icache_addr, pc_from_fetch, fetch_count, icache_req);
        end
        icache_hit = 1'b1;
        @(negedge clk);
        rst_h = 1'b0;
        #1;
        checks++;
        if (instr_to_decoder !== 32'h1300_0100) begin errors++; $display("FAIL post_reset_fetch got %h want 13000100", instr_to_decoder); end
    endtask

    initial begin
        rst_h = 1'b1;
        icache_hit = 1'b1;
        stall_from_decoder = 1'b0;
        branch_taken_from_execute = 1'b0;
        branch_target_from_execute = 32'h0;
        test_reset();
        test_sequential();
        test_miss();
        test_stall();
        test_redirect();
        test_misaligned();
        test_wrap_and_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
